// File: rtl/data_compact_buffer.sv
// data_compact_buffer
//   Packs the valid lanes of each accepted input beat, in ascending lane order,
//   behind a residual store and emits dense LANES-wide words over valid/ready.
//   A flush pushes out whatever is held as a zero-padded partial word; when the
//   flush beat overflows a full word, the leftover is emitted from DRAIN next.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valids       per-lane valid for in_data
//   in_data         lane i at [i*DATA_W +: DATA_W]
//   in_flush        flush request, qualified by beat acceptance
//   in_ready        beat accepted when high at the clock edge
//   out_valid       output word available
//   out_ready       consumer accepts the word when out_valid & out_ready
//   out_data        packed word, entry 0 in lane 0, unused lanes zero
//   out_count       meaningful lanes in out_data
//   fill_level      residual entries currently held (0..LANES-1)
module data_compact_buffer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CW    = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        in_valids,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_flush,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CW-1:0]           out_count,
  output logic [CW-1:0]           fill_level
);

  // Combined sequence can reach 2*LANES-1 entries.
  localparam int unsigned TW = $clog2(2 * LANES);
  localparam int unsigned NC = 2 * LANES - 1;

  typedef enum logic [0:0] {StAccum, StDrain} state_e;

  state_e                    r_state, w_state_next;
  logic                      r_out_valid, w_out_valid_next;
  logic [LANES*DATA_W-1:0]   r_out_data, w_out_data_next;
  logic [CW-1:0]             r_out_count, w_out_count_next;
  logic [CW-1:0]             r_fill, w_fill_next;
  logic [DATA_W-1:0]         r_res      [LANES-1];
  logic [DATA_W-1:0]         w_res_next [LANES-1];

  logic [CW-1:0]             w_prefix [LANES];
  logic [CW-1:0]             w_k;
  logic [TW-1:0]             w_total;
  logic [DATA_W-1:0]         w_comb [NC];
  logic                      w_slot_free;
  logic                      w_accept;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = rst_n && (r_state == StAccum) && w_slot_free;
  assign w_accept    = in_ready;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_count  = r_out_count;
  assign fill_level = r_fill;

  // Exclusive prefix popcount: destination offset of each valid lane.
  always_comb begin
    w_k = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prefix[i] = w_k;
      w_k         = w_k + CW'(in_valids[i]);
    end
  end

  assign w_total = TW'(r_fill) + TW'(w_k);

  // Compaction network. Slots below fill_level come from the residual; every
  // slot at or above it picks the single valid lane whose offset lands there.
  // Residual entries at or above fill_level are zero, so OR-merging is safe.
  always_comb begin
    for (int j = 0; j < LANES - 1; j++) begin
      w_comb[j] = r_res[j];
    end
    for (int j = LANES - 1; j < NC; j++) begin
      w_comb[j] = '0;
    end
    for (int j = 0; j < NC; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valids[i] && (TW'(w_prefix[i]) + TW'(r_fill) == TW'(j))) begin
          w_comb[j] = w_comb[j] | in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_count_next = r_out_count;
    w_fill_next      = r_fill;
    w_res_next       = r_res;

    if (r_out_valid && out_ready) begin
      w_out_valid_next = 1'b0;
    end

    case (r_state)
      StAccum: begin
        if (w_accept) begin
          if (w_total >= TW'(LANES)) begin
            for (int j = 0; j < LANES; j++) begin
              w_out_data_next[j*DATA_W +: DATA_W] = w_comb[j];
            end
            w_out_count_next = CW'(LANES);
            w_out_valid_next = 1'b1;
            for (int j = 0; j < LANES - 1; j++) begin
              w_res_next[j] = w_comb[LANES + j];
            end
            w_fill_next = CW'(w_total - TW'(LANES));
            // Leftover after a flush goes out as a second, partial word.
            if (in_flush && (w_total > TW'(LANES))) begin
              w_state_next = StDrain;
            end
          end else if (in_flush && (w_total != '0)) begin
            for (int j = 0; j < LANES; j++) begin
              w_out_data_next[j*DATA_W +: DATA_W] = w_comb[j];
            end
            w_out_count_next = CW'(w_total);
            w_out_valid_next = 1'b1;
            w_fill_next      = '0;
            for (int j = 0; j < LANES - 1; j++) begin
              w_res_next[j] = '0;
            end
          end else begin
            for (int j = 0; j < LANES - 1; j++) begin
              w_res_next[j] = w_comb[j];
            end
            w_fill_next = CW'(w_total);
          end
        end
      end
      StDrain: begin
        if (w_slot_free) begin
          w_out_data_next = '0;
          for (int j = 0; j < LANES - 1; j++) begin
            w_out_data_next[j*DATA_W +: DATA_W] = r_res[j];
            w_res_next[j]                       = '0;
          end
          w_out_count_next = r_fill;
          w_out_valid_next = 1'b1;
          w_fill_next      = '0;
          w_state_next     = StAccum;
        end
      end
      default: w_state_next = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StAccum;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_fill      <= '0;
      for (int j = 0; j < LANES - 1; j++) begin
        r_res[j] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_count <= w_out_count_next;
      r_fill      <= w_fill_next;
      for (int j = 0; j < LANES - 1; j++) begin
        r_res[j] <= w_res_next[j];
      end
    end
  end

endmodule

// File: tb/tb_data_compact_buffer.sv
// Bench for data_compact_buffer (LANES=16, DATA_W=32): directed scenarios with
// literal expectations plus randomized traffic, all checked against a
// queue-based model of the packing rules every cycle.
module tb_data_compact_buffer;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int CW     = 5;
  localparam int BW     = LANES * DATA_W;

  logic              clk;
  logic              rst_n;
  logic [LANES-1:0]  in_valids;
  logic [BW-1:0]     in_data;
  logic              in_flush;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [CW-1:0]     out_count;
  logic [CW-1:0]     fill_level;

  data_compact_buffer #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valids  (in_valids),
    .in_data    (in_data),
    .in_flush   (in_flush),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model: residual as a FIFO of lane values, plus the pending output word.
  logic [DATA_W-1:0] m_res[$];
  bit                m_valid;
  bit                m_drain;
  logic [BW-1:0]     m_data;
  int                m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] lane(input int i);
    return out_data[i*DATA_W +: DATA_W];
  endfunction

  function automatic bit m_ready();
    return rst_n && !m_drain && (!m_valid || out_ready);
  endfunction

  task automatic m_reset();
    m_res.delete();
    m_valid = 1'b0;
    m_drain = 1'b0;
    m_data  = '0;
    m_count = 0;
  endtask

  task automatic m_emit(input int n);
    m_data = '0;
    for (int k = 0; k < n; k++) m_data[k*DATA_W +: DATA_W] = m_res.pop_front();
    m_count = n;
    m_valid = 1'b1;
  endtask

  task automatic m_step();
    bit slot;
    if (!rst_n) return;
    slot = !m_valid || out_ready;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (m_drain) begin
      if (slot) begin
        m_emit(m_res.size());
        m_drain = 1'b0;
      end
    end else if (slot) begin
      for (int i = 0; i < LANES; i++)
        if (in_valids[i]) m_res.push_back(in_data[i*DATA_W +: DATA_W]);
      if (m_res.size() >= LANES) begin
        m_emit(LANES);
        if (in_flush && m_res.size() > 0) m_drain = 1'b1;
      end else if (in_flush && m_res.size() > 0) begin
        m_emit(m_res.size());
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", in_ready, m_ready());
    chk("out_valid", out_valid, m_valid);
    chk("fill_level", fill_level, m_res.size());
    if (m_valid) begin
      chk("out_count", out_count, m_count);
      chk_bus("out_data", out_data, m_data);
    end
  endtask

  // Advance one clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic [LANES-1:0] v, input logic [DATA_W-1:0] base, input bit fl);
    in_valids = v;
    in_flush  = fl;
    for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = base + DATA_W'(i);
  endtask

  task automatic idle();
    in_valids = '0;
    in_flush  = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    idle();
    m_reset();

    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_count", out_count, 0);
    chk("reset fill_level", fill_level, 0);
    chk("reset in_ready", in_ready, 0);
    chk_bus("reset out_data", out_data, '0);

    // Full beat straight after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hFFFF, 32'h0, 1'b0);
    step();
    chk("t1 out_valid", out_valid, 1);
    chk("t1 out_count", out_count, 16);
    chk("t1 lane0", lane(0), 0);
    chk("t1 lane15", lane(15), 15);
    chk("t1 fill", fill_level, 0);
    idle();
    step();

    // Two half beats combine into one word.
    drive(16'h00FF, 32'h10, 1'b0);
    step();
    chk("t2 fill after first", fill_level, 8);
    chk("t2 no output", out_valid, 0);
    drive(16'hFF00, 32'h20, 1'b0);
    step();
    chk("t2 lane7", lane(7), 32'h17);
    chk("t2 lane8", lane(8), 32'h28);
    chk("t2 lane15", lane(15), 32'h2F);
    chk("t2 fill", fill_level, 0);
    idle();
    step();

    // Flush of a partial word.
    drive(16'h0007, 32'hA0, 1'b0);
    step();
    chk("t3 fill 3", fill_level, 3);
    drive(16'h0005, 32'hD0, 1'b1);
    step();
    chk("t3 out_count", out_count, 5);
    chk("t3 lane2", lane(2), 32'hA2);
    chk("t3 lane3", lane(3), 32'hD0);
    chk("t3 lane4", lane(4), 32'hD2);
    chk("t3 lane5 zero", lane(5), 0);
    chk("t3 fill", fill_level, 0);
    idle();
    step();

    // Flush that overflows: full word, then drained partial word.
    drive(16'h03FF, 32'h100, 1'b0);
    step();
    chk("t4 fill 10", fill_level, 10);
    drive(16'hFFFF, 32'h200, 1'b1);
    step();
    chk("t4 full count", out_count, 16);
    chk("t4 lane9", lane(9), 32'h109);
    chk("t4 lane10", lane(10), 32'h200);
    chk("t4 lane15", lane(15), 32'h205);
    chk("t4 drain in_ready", in_ready, 0);
    chk("t4 drain fill", fill_level, 10);
    idle();
    step();
    chk("t4 partial count", out_count, 10);
    chk("t4 partial lane0", lane(0), 32'h206);
    chk("t4 partial lane9", lane(9), 32'h20F);
    chk("t4 partial lane10", lane(10), 0);
    chk("t4 in_ready back", in_ready, 1);
    chk("t4 fill", fill_level, 0);
    step();

    // Back-pressure holds the word; release gives same-edge reload.
    out_ready = 1'b0;
    drive(16'hFFFF, 32'h300, 1'b0);
    step();
    drive(16'hFFFF, 32'h400, 1'b0);
    repeat (5) begin
      step();
      chk("t5 stall in_ready", in_ready, 0);
      chk("t5 hold lane0", lane(0), 32'h300);
      chk("t5 hold count", out_count, 16);
    end
    out_ready = 1'b1;
    #1;
    chk("t5 release in_ready", in_ready, 1);
    step();
    chk("t5 reload lane0", lane(0), 32'h400);
    chk("t5 reload valid", out_valid, 1);
    idle();
    step();

    // Asynchronous reset with residual and pending word.
    drive(16'h007F, 32'h500, 1'b0);
    step();
    drive(16'hFFFF, 32'h600, 1'b0);
    step();
    chk("t6 valid before", out_valid, 1);
    chk("t6 fill before", fill_level, 7);
    idle();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async out_valid", out_valid, 0);
    chk("t6 async out_count", out_count, 0);
    chk("t6 async fill", fill_level, 0);
    chk("t6 async in_ready", in_ready, 0);
    m_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("t6 no partial", out_valid, 0);
    end

    // Randomized traffic against the model.
    repeat (3000) begin
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       in_valids = '0;
        1:       in_valids = LANES'($urandom & $urandom);
        2:       in_valids = '1;
        default: in_valids = LANES'($urandom);
      endcase
      in_flush  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_compact_buffer.md
Name: data_compact_buffer

Overview:
- Parametrised successor to the 16-lane fixed valid-compaction buffer.
- Packs the valid lanes of each input beat, in ascending lane order, into a running residual store.
- Emits dense LANES-wide output words through a valid/ready handshake.
- Flush emits a zero-padded partial word. Sits between sparse lane producers and downstream consumers that expect packed data.

Parameters:
- LANES, 16, number of lanes per beat (2..32)
- DATA_W, 32, bits per lane
- CW, $clog2(LANES+1), width of count fields (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valids  in  LANES  per-lane valid; bit i qualifies in_data lane i
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_flush  in  1  flush request, qualified by beat acceptance
- in_ready  out  1  beat accepted when high at clk edge
- out_valid  out  1  output word available
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_data  out  LANES*DATA_W  packed word; entry 0 in lane 0
- out_count  out  CW  number of meaningful lanes in out_data (1..LANES)
- fill_level  out  CW  residual entries held (0..LANES-1)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_count=0, fill_level=0, state=ACCUM, residual store cleared. in_ready is forced to 0 while rst_n is low.
- slot_free = !out_valid | out_ready.
- in_ready = (state==ACCUM) & slot_free, combinational. It is never asserted in DRAIN.
- Accept = in_ready at clk edge. The beat is consumed whatever in_valids holds. A zero-valid beat without flush is a no-op.
- On accept: K=popcount(in_valids), F=fill_level. Combined sequence = residual[0..F-1] followed by the valid lanes in ascending index order. T=F+K (max 2*LANES-1).
- T>=LANES: out_data<=combined[0..LANES-1], out_count<=LANES, out_valid<=1. Residual <= combined[LANES..T-1], fill_level<=T-LANES.
- T<LANES and no flush: residual<=combined, fill_level<=T. out_valid<=0 if it was handshaken this cycle.
- Flush on accept, T<LANES, T>0: out_data<=combined, upper LANES-T lanes zero, out_count<=T, out_valid<=1, fill_level<=0. State stays ACCUM.
- Flush on accept, T==0: no output; state unchanged.
- Flush on accept, T>LANES: emit the full word as above, residual=T-LANES, state<=DRAIN.
- Flush on accept, T==LANES: full word only, fill_level=0, stay ACCUM.
- DRAIN: wait for slot_free. Then emit the residual as a partial word (out_count=fill_level, zero-padded), fill_level<=0, state<=ACCUM.
- Output hold: while out_valid & !out_ready, out_data and out_count are stable.
- Back-to-back: a full word accepted by the consumer and a new word loaded in the same edge is legal and gives 100% throughput.
- Latency: accepted beat to out_valid is 1 cycle.
- Residual entries and unused out_data lanes are stored as zero so fill_level alone defines content.
- Reset mid-operation discards the residual and any pending word; no partial emission.
- Internal implementation uses a prefix-popcount compaction network (one mux select per output slot). Residual is a LANES-1 entry register file.

Test Plan (LANES=16, DATA_W=32):
1. Reset release, in_valids=16'hFFFF, lane i=i, out_ready=1 -> next cycle out_valid=1, out_count=16, lanes 0..15 = 0..15, fill_level=0.
2. Beats in_valids=16'h00FF (lanes 0x10..0x17), then 16'hFF00 (lanes 0x28..0x2F).
   - After the first beat: no output, fill_level=8.
   - After the second beat: out_data = 0x10..0x17, 0x28..0x2F; fill_level=0.
3. fill_level=3 (A,B,C), in_flush=1 with in_valids=16'h0005 (D,E in lanes 0,2) -> out_count=5, lanes 0..4=A,B,C,D,E, lanes 5..15=0, fill_level=0.
4. fill_level=10, in_flush=1, in_valids=16'hFFFF.
   - Full word out (10 residual + lanes 0..5); state DRAIN, in_ready=0.
   - Then partial word out_count=10 = lanes 6..15; in_ready returns to 1.
5. out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0, out_data/out_count unchanged. On release, the word transfers and the next beat is accepted the same cycle.
6. rst_n pulled low asynchronously mid-clock with fill_level=7 and out_valid=1 -> out_valid, out_count, fill_level all 0 immediately (before next clk edge). No partial word after release.
